cmps_rd_seq: RTL and testbench

//  Memory-side sequencer for CMPS/REP CMPS. Reads [ESI], latches it as the first operand, then reads [EDI].

---
 rtl/cmps_rd_seq_pkg.sv | 28 ++
 rtl/cmps_rd_seq_step_gen.sv | 26 ++
 rtl/cmps_rd_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_cmps_rd_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmps_rd_seq_pkg.sv
// Shared definitions for the CMPS memory-side read sequencer.
// Optional feature macro: CMPS_REP_EN (REPE/REPNE iteration).
package cmps_rd_seq_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_WORD    = 2'b01;
  localparam logic [1:0] SZ_DWORD   = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] REP_E  = 2'b01;
  localparam logic [1:0] REP_NE = 2'b10;

  // True for the two repeat prefixes; 2'b11 behaves like no prefix.
  function automatic logic is_rep(input logic [1:0] rep);
    return (rep == REP_E) || (rep == REP_NE);
  endfunction

endpackage

// File: rtl/cmps_rd_seq_step_gen.sv
// Pointer step generator for string instructions: +/-1/2/4 by size and DF.
module cmps_rd_seq_step_gen
  import cmps_rd_seq_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [1:0]    op_size,
  input  logic          df,
  output logic [AW-1:0] step_c
);

  logic [AW-1:0] mag;

  // Magnitude from size, two's-complement negated when counting down.
  always_comb begin
    mag = '0;
    case (op_size)
      SZ_BYTE:  mag = AW'(1);
      SZ_WORD:  mag = AW'(2);
      SZ_DWORD: mag = AW'(4);
      default:  mag = '0;
    endcase
    step_c = df ? (~mag + AW'(1)) : mag;
  end

endmodule

// File: rtl/cmps_rd_seq.sv
// CMPS / REP CMPS memory-side sequencer: reads [ESI] then [EDI], hands both
// operands to the ALU, steps pointers and (with CMPS_REP_EN) counts ECX down.
// Optional feature macro: CMPS_REP_EN.
module cmps_rd_seq
  import cmps_rd_seq_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       rep_mode,
  input  logic [1:0]       op_size,
  input  logic             df,
  input  logic [AW-1:0]    esi_in,
  input  logic [AW-1:0]    edi_in,
  input  logic [CNT_W-1:0] ecx_in,
  input  logic             abort,
  output logic             mem_rd_req,
  output logic [AW-1:0]    mem_rd_addr,
  output logic [1:0]       mem_rd_size,
  input  logic             mem_rd_ack,
  input  logic [DW-1:0]    mem_rd_data,
  output logic [DW-1:0]    mem_out_latched,
  output logic [DW-1:0]    mem_out,
  output logic             cmps_valid,
  input  logic             cmps_zf,
  output logic [AW-1:0]    esi_out,
  output logic [AW-1:0]    edi_out,
  output logic [CNT_W-1:0] ecx_out,
  output logic             busy,
  output logic             done,
  output logic             err_size
);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             df_q, df_d;
  logic [DW-1:0]    lat_q, lat_d;
  logic [DW-1:0]    out_q, out_d;
  logic [AW-1:0]    esi_q, esi_d;
  logic [AW-1:0]    edi_q, edi_d;
  logic [CNT_W-1:0] ecx_q, ecx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             skip_c;
  logic             cont_c;
  logic [AW-1:0]    step_c;

`ifdef CMPS_REP_EN
  logic [1:0]       rep_q, rep_d;
`else
  logic             unused_rep_c;
  assign unused_rep_c = ^{rep_mode, cmps_zf};
`endif

  // Zero-extend read data to the latched operand size.
  function automatic logic [DW-1:0] zext(input logic [DW-1:0] d, input logic [1:0] sz);
    logic [DW-1:0] r;
    r = d;
    case (sz)
      SZ_BYTE: r = DW'(d[7:0]);
      SZ_WORD: r = DW'(d[15:0]);
      default: r = d;
    endcase
    return r;
  endfunction

  cmps_rd_seq_step_gen #(.AW(AW)) u_step (
    .op_size (size_q),
    .df      (df_q),
    .step_c  (step_c)
  );

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    size_d  = size_q;
    df_d    = df_q;
    lat_d   = lat_q;
    out_d   = out_q;
    esi_d   = esi_q;
    edi_d   = edi_q;
    ecx_d   = ecx_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    skip_c  = 1'b0;
    cont_c  = 1'b0;
`ifdef CMPS_REP_EN
    rep_d   = rep_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_size == SZ_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            size_d = op_size;
            df_d   = df;
            esi_d  = esi_in;
            edi_d  = edi_in;
            ecx_d  = ecx_in;
`ifdef CMPS_REP_EN
            rep_d  = rep_mode;
            skip_c = is_rep(rep_mode) && (ecx_in == '0);
`endif
            if (skip_c) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RD1;
              req_d   = 1'b1;
              addr_d  = esi_in;
            end
          end
        end
      end
      ST_RD1: begin
        if (mem_rd_ack) begin
          lat_d   = zext(mem_rd_data, size_q);
          state_d = ST_RD2;
          addr_d  = edi_q;
        end
      end
      ST_RD2: begin
        if (mem_rd_ack) begin
          out_d   = zext(mem_rd_data, size_q);
          state_d = ST_CMP;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      ST_CMP: begin
        esi_d = esi_q + step_c;
        edi_d = edi_q + step_c;
`ifdef CMPS_REP_EN
        if (is_rep(rep_q)) begin
          ecx_d = ecx_q - CNT_W'(1);
        end
        cont_c = is_rep(rep_q) && (ecx_d != '0) && ((rep_q == REP_E) == cmps_zf);
`endif
        if (cont_c) begin
          state_d = ST_RD1;
          req_d   = 1'b1;
          addr_d  = esi_d;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      size_d  = size_q;
      df_d    = df_q;
      lat_d   = lat_q;
      out_d   = out_q;
      esi_d   = esi_q;
      edi_d   = edi_q;
      ecx_d   = ecx_q;
`ifdef CMPS_REP_EN
      rep_d   = rep_q;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      df_q    <= 1'b0;
      lat_q   <= '0;
      out_q   <= '0;
      esi_q   <= '0;
      edi_q   <= '0;
      ecx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CMPS_REP_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      df_q    <= df_d;
      lat_q   <= lat_d;
      out_q   <= out_d;
      esi_q   <= esi_d;
      edi_q   <= edi_d;
      ecx_q   <= ecx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CMPS_REP_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign mem_rd_req      = req_q;
  assign mem_rd_addr     = addr_q;
  assign mem_rd_size     = size_q;
  assign mem_out_latched = lat_q;
  assign mem_out         = out_q;
  assign cmps_valid      = valid_q;
  assign esi_out         = esi_q;
  assign edi_out         = edi_q;
  assign ecx_out         = ecx_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_size        = err_q;

endmodule

// File: tb/tb_cmps_rd_seq.sv
// Self-checking bench for cmps_rd_seq: memory responder plus scoreboard of
// expected read addresses and compare operands.
module tb_cmps_rd_seq;
  import cmps_rd_seq_pkg::*;

  logic        clk, rst_n, start, df, abort;
  logic [1:0]  rep_mode, op_size;
  logic [31:0] esi_in, edi_in, ecx_in;
  logic        mem_rd_req, mem_rd_ack;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic [1:0]  mem_rd_size;
  logic [31:0] mem_out_latched, mem_out;
  logic        cmps_valid, cmps_zf;
  logic [31:0] esi_out, edi_out, ecx_out;
  logic        busy, done, err_size;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_op_q[$];
  logic        zf_q[$];

  int          done_cnt, valid_cnt, done_cyc, rd_cnt, req_cyc;
  logic        req_after_abort, end_busy;
  logic [31:0] wait_addr, last_lat;

  cmps_rd_seq #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rep_mode(rep_mode), .op_size(op_size),
    .df(df), .esi_in(esi_in), .edi_in(edi_in), .ecx_in(ecx_in), .abort(abort),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_size(mem_rd_size),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .mem_out_latched(mem_out_latched), .mem_out(mem_out), .cmps_valid(cmps_valid),
    .cmps_zf(cmps_zf), .esi_out(esi_out), .edi_out(edi_out), .ecx_out(ecx_out),
    .busy(busy), .done(done), .err_size(err_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hFFFF_FFFF) return 32'hAABB_CCDD;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] bzext(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'b00) return {24'h0, d[7:0]};
    if (sz == 2'b01) return {16'h0, d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] step_of(input logic [1:0] sz, input logic d);
    logic [31:0] m;
    m = (sz == 2'b00) ? 32'd1 : (sz == 2'b01) ? 32'd2 : 32'd4;
    return d ? (32'd0 - m) : m;
  endfunction

  // Push the expected addresses and operand pairs for n iterations.
  task automatic plan_iters(input logic [31:0] esi, input logic [31:0] edi,
                            input logic [1:0] sz, input logic d, input int n);
    logic [31:0] a, b;
    for (int k = 0; k < n; k++) begin
      a = esi + 32'(k) * step_of(sz, d);
      b = edi + 32'(k) * step_of(sz, d);
      exp_addr_q.push_back(a);
      exp_addr_q.push_back(b);
      exp_op_q.push_back({bzext(mem_word(a), sz), bzext(mem_word(b), sz)});
    end
  endtask

  // Launch one instruction and act as the memory/ALU; scoreboard pops on DUT output.
  task automatic run_instr(input logic [31:0] esi, input logic [31:0] edi, input logic [31:0] ecx,
                           input logic [1:0] sz, input logic [1:0] rp, input logic d,
                           input int wait2, input int abort_at, input int restart_at,
                           input int max_cyc);
    int   cyc, wcnt;
    bit   aborted, rd2;
    logic [63:0] eo;
    logic [31:0] ea;
    done_cnt = 0; valid_cnt = 0; done_cyc = -1; rd_cnt = 0; req_cyc = 0;
    req_after_abort = 1'b0; wait_addr = '0; last_lat = '0;
    @(negedge clk);
    start = 1'b1; esi_in = esi; edi_in = edi; ecx_in = ecx; op_size = sz; rep_mode = rp; df = d;
    cyc = 0; wcnt = 0; aborted = 0; rd2 = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0; mem_rd_ack = 1'b0; mem_rd_data = '0; cmps_zf = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1; esi_in = 32'hDEAD_BEE0; edi_in = 32'hCAFE_0000; ecx_in = 32'd99;
      end
      if (cmps_valid) begin
        valid_cnt++;
        last_lat = mem_out_latched;
        n_checks++;
        if (exp_op_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmps_operands: got %h/%h, required no compare", mem_out_latched, mem_out);
        end else begin
          eo = exp_op_q.pop_front();
          if ({mem_out_latched, mem_out} !== eo) begin
            n_fail++;
            $display("FAIL cmps_operands: got %h/%h, required %h/%h",
                     mem_out_latched, mem_out, eo[63:32], eo[31:0]);
          end
        end
        if (zf_q.size() != 0) cmps_zf = zf_q.pop_front();
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (mem_rd_req) req_cyc++;
      if (aborted) begin
        aborted = 0;
        req_after_abort = mem_rd_req;
        mem_rd_ack = 1'b1;
        mem_rd_data = 32'hFFFF_FFFF;
      end else if (mem_rd_req) begin
        if (rd2 && wcnt < wait2) begin
          if (wcnt == 0) wait_addr = mem_rd_addr;
          else begin
            n_checks++;
            if (mem_rd_addr !== wait_addr) begin
              n_fail++;
              $display("FAIL addr_stable: got %h, required %h", mem_rd_addr, wait_addr);
            end
          end
          wcnt++;
          if (wcnt == abort_at) begin
            abort = 1'b1;
            aborted = 1;
          end
        end else begin
          mem_rd_ack = 1'b1;
          mem_rd_data = mem_word(mem_rd_addr);
          rd_cnt++;
          n_checks++;
          if (exp_addr_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_addr: got %h, required no read", mem_rd_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            if (mem_rd_addr !== ea) begin
              n_fail++;
              $display("FAIL rd_addr: got %h, required %h", mem_rd_addr, ea);
            end
          end
          n_checks++;
          if (mem_rd_size !== sz) begin
            n_fail++;
            $display("FAIL rd_size: got %0d, required %0d", mem_rd_size, sz);
          end
          rd2 = !rd2;
          wcnt = 0;
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
    end
    end_busy = busy;
    n_checks++;
    if (exp_addr_q.size() != 0 || exp_op_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d addr/%0d ops left, required 0/0",
               exp_addr_q.size(), exp_op_q.size());
    end
    exp_addr_q.delete(); exp_op_q.delete(); zf_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; rep_mode = 0; op_size = 0; df = 0;
    esi_in = 0; edi_in = 0; ecx_in = 0; mem_rd_ack = 0; mem_rd_data = 0; cmps_zf = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (|{mem_rd_req, mem_rd_addr, mem_rd_size, mem_out_latched, mem_out, cmps_valid,
          esi_out, edi_out, ecx_out, busy, done, err_size} !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero output, required all zero");
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, mem_rd_req, cmps_valid, esi_out} !== 36'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b done=%b req=%b, required 0", busy, done, mem_rd_req);
    end
  endtask

  task automatic test_single_dword();
    plan_iters(32'h100, 32'h200, SZ_DWORD, 1'b0, 1);
    zf_q.push_back(1'b0);
    run_instr(32'h100, 32'h200, 32'd7, SZ_DWORD, 2'b00, 1'b0, 0, -1, -1, 20);
    n_checks++;
    if (done_cyc !== 4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL single_done: got cyc %0d cnt %0d, required 4/1", done_cyc, done_cnt);
    end
    n_checks++;
    if ({esi_out, edi_out, ecx_out} !== {32'h104, 32'h204, 32'd7}) begin
      n_fail++; $display("FAIL single_ptrs: got %h %h %0d, required 104 204 7", esi_out, edi_out, ecx_out);
    end
    n_checks++;
    if (end_busy !== 1'b0 || valid_cnt !== 1) begin
      n_fail++; $display("FAIL single_idle: got busy %b valids %0d, required 0/1", end_busy, valid_cnt);
    end
  endtask

  task automatic test_repe_byte();
    int n, edc;
    logic [31:0] eecx;
`ifdef CMPS_REP_EN
    n = 3; edc = 10; eecx = 32'd0;
`else
    n = 1; edc = 4; eecx = 32'd3;
`endif
    plan_iters(32'h1000, 32'h2000, SZ_BYTE, 1'b1, n);
    for (int k = 0; k < n; k++) zf_q.push_back(1'b1);
    run_instr(32'h1000, 32'h2000, 32'd3, SZ_BYTE, 2'b01, 1'b1, 0, -1, -1, 40);
    n_checks++;
    if (valid_cnt !== n || done_cyc !== edc) begin
      n_fail++; $display("FAIL repe_count: got %0d valids done@%0d, required %0d done@%0d", valid_cnt, done_cyc, n, edc);
    end
    n_checks++;
    if ({esi_out, edi_out, ecx_out} !== {32'h1000 - 32'(n), 32'h2000 - 32'(n), eecx}) begin
      n_fail++; $display("FAIL repe_regs: got %h %h %0d, required %h %h %0d", esi_out, edi_out, ecx_out,
                         32'h1000 - 32'(n), 32'h2000 - 32'(n), eecx);
    end
  endtask

  task automatic test_repne_word();
    int n, edc;
    logic [31:0] eecx;
`ifdef CMPS_REP_EN
    n = 2; edc = 7; eecx = 32'd3;
    zf_q.push_back(1'b0); zf_q.push_back(1'b1);
`else
    n = 1; edc = 4; eecx = 32'd5;
    zf_q.push_back(1'b0);
`endif
    plan_iters(32'h300, 32'h400, SZ_WORD, 1'b0, n);
    run_instr(32'h300, 32'h400, 32'd5, SZ_WORD, 2'b10, 1'b0, 0, -1, -1, 40);
    n_checks++;
    if (valid_cnt !== n || done_cyc !== edc) begin
      n_fail++; $display("FAIL repne_count: got %0d valids done@%0d, required %0d done@%0d", valid_cnt, done_cyc, n, edc);
    end
    n_checks++;
    if ({esi_out, edi_out, ecx_out} !== {32'h300 + 32'(2 * n), 32'h400 + 32'(2 * n), eecx}) begin
      n_fail++; $display("FAIL repne_regs: got %h %h %0d, required ptr+%0d ecx %0d", esi_out, edi_out, ecx_out, 2 * n, eecx);
    end
  endtask

  task automatic test_rep_zero_ecx();
    int edc, ereq;
    logic [31:0] eesi;
`ifdef CMPS_REP_EN
    edc = 1; ereq = 0; eesi = 32'h500;
`else
    edc = 4; ereq = 2; eesi = 32'h504;
    plan_iters(32'h500, 32'h600, SZ_DWORD, 1'b0, 1);
    zf_q.push_back(1'b1);
`endif
    run_instr(32'h500, 32'h600, 32'd0, SZ_DWORD, 2'b01, 1'b0, 0, -1, -1, 20);
    n_checks++;
    if (done_cyc !== edc || req_cyc !== ereq) begin
      n_fail++; $display("FAIL zero_ecx_timing: got done@%0d req cycles %0d, required %0d/%0d", done_cyc, req_cyc, edc, ereq);
    end
    n_checks++;
    if ({esi_out, ecx_out} !== {eesi, 32'd0}) begin
      n_fail++; $display("FAIL zero_ecx_regs: got %h %0d, required %h 0", esi_out, ecx_out, eesi);
    end
  endtask

  task automatic test_abort();
    exp_addr_q.push_back(32'h700);
    run_instr(32'h700, 32'h800, 32'd9, SZ_DWORD, 2'b00, 1'b0, 3, 2, -1, 12);
    n_checks++;
    if (done_cnt !== 0 || valid_cnt !== 0 || rd_cnt !== 1) begin
      n_fail++; $display("FAIL abort_activity: got done %0d valid %0d reads %0d, required 0/0/1", done_cnt, valid_cnt, rd_cnt);
    end
    n_checks++;
    if ({esi_out, edi_out, ecx_out} !== {32'h700, 32'h800, 32'd9}) begin
      n_fail++; $display("FAIL abort_regs: got %h %h %0d, required 700 800 9", esi_out, edi_out, ecx_out);
    end
    n_checks++;
    if (req_after_abort !== 1'b0 || end_busy !== 1'b0 || wait_addr !== 32'h800) begin
      n_fail++; $display("FAIL abort_req: got req %b busy %b wait addr %h, required 0 0 800", req_after_abort, end_busy, wait_addr);
    end
  endtask

  task automatic test_wrap_byte();
    plan_iters(32'hFFFF_FFFF, 32'h10, SZ_BYTE, 1'b0, 1);
    zf_q.push_back(1'b0);
    run_instr(32'hFFFF_FFFF, 32'h10, 32'd1, SZ_BYTE, 2'b00, 1'b0, 0, -1, -1, 20);
    n_checks++;
    if (last_lat !== 32'h0000_00DD) begin
      n_fail++; $display("FAIL wrap_operand: got %h, required 000000dd", last_lat);
    end
    n_checks++;
    if ({esi_out, edi_out} !== {32'h0, 32'h11}) begin
      n_fail++; $display("FAIL wrap_ptrs: got %h %h, required 0 11", esi_out, edi_out);
    end
  endtask

  task automatic test_err_size();
    @(negedge clk);
    start = 1'b1; op_size = SZ_ILLEGAL; esi_in = 32'h40;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({err_size, busy, mem_rd_req} !== 3'b100) begin
      n_fail++; $display("FAIL err_pulse: got err %b busy %b req %b, required 1 0 0", err_size, busy, mem_rd_req);
    end
    @(negedge clk);
    n_checks++;
    if ({err_size, busy} !== 2'b00) begin
      n_fail++; $display("FAIL err_clear: got err %b busy %b, required 0 0", err_size, busy);
    end
  endtask

  task automatic test_back_to_back();
    plan_iters(32'h900, 32'hA00, SZ_DWORD, 1'b0, 1);
    zf_q.push_back(1'b0);
    run_instr(32'h900, 32'hA00, 32'd4, SZ_DWORD, 2'b00, 1'b0, 0, -1, 2, 20);
    n_checks++;
    if (done_cyc !== 4 || done_cnt !== 1 || esi_out !== 32'h904) begin
      n_fail++; $display("FAIL busy_start: got done@%0d cnt %0d esi %h, required 4/1/904", done_cyc, done_cnt, esi_out);
    end
    plan_iters(32'hB00, 32'hC00, SZ_WORD, 1'b1, 1);
    zf_q.push_back(1'b1);
    run_instr(32'hB00, 32'hC00, 32'd2, SZ_WORD, 2'b00, 1'b1, 2, -1, -1, 20);
    n_checks++;
    if (done_cyc !== 6 || {esi_out, edi_out} !== {32'hAFE, 32'hBFE}) begin
      n_fail++; $display("FAIL wait_latency: got done@%0d %h %h, required 6 afe bfe", done_cyc, esi_out, edi_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_dword();
    test_repe_byte();
    test_repne_word();
    test_rep_zero_ecx();
    test_abort();
    test_wrap_byte();
    test_err_size();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
